ring_ni_tx: RTL and testbench
=============================

RING_NI_TX -- requirements
Module: ring_ni_tx

Interface
REQ-001 SHALL have parameter CREDITS, default 8, meaning the number of downstream router local-FIFO slots, range 1..15.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  meaning reset; it is synchronous and active-low.
REQ-004 SHALL have port my_addr  input  4  meaning the node address, stable after reset.
REQ-005 SHALL have port n  input  4  meaning the ring node count, with legal destinations 0..n-1.
REQ-006 SHALL have port req_valid  input  1  meaning a packet request is present.
REQ-007 SHALL have port req_dest  input  4  meaning the destination node.
REQ-008 SHALL have port req_len  input  4  meaning the number of payload flits, 0..15.
REQ-009 SHALL have port req_ready  output  1  meaning a request can be accepted; high only in IDLE.
REQ-010 SHALL have port data_valid  input  1  meaning payload data_in is present.
REQ-011 SHALL have port data_in  input  54  meaning one payload word.
REQ-012 SHALL have port data_ready  output  1  meaning data_in is consumed this cycle.
REQ-013 SHALL have port flit_out  output  64  meaning a registered flit into the router local FIFO.
REQ-014 SHALL have port flit_valid  output  1  meaning flit_out is valid (FIFO write enable).
REQ-015 SHALL have port credit_ret  input  1  meaning a one-cycle pulse per freed downstream slot.
REQ-016 SHALL have port err_dest  output  1  meaning a one-cycle pulse when a request is rejected.
REQ-017 SHALL have port credit_err  output  1  meaning a sticky credit-overflow flag.
REQ-018 SHALL have port flits_sent  output  16  meaning a wrapping count of emitted flits.

Function
REQ-019 SHALL format every flit as [3:0]=my_addr, [7:4]=dest, [9:8]=type, with type 00 head, 01 body, 10 tail, 11 single.
REQ-020 SHALL format the head/single flit payload as [13:10]=len, [17:14]=seq, and [63:18]=0.
REQ-021 SHALL format the body/tail flit payload as [63:10]=data_in.
REQ-022 SHALL implement FSM states IDLE, HEAD, and BODY.
REQ-023 SHALL, in IDLE with req_valid high, accept the request on that edge and latch dest and len.
REQ-024 SHALL reject the request if req_dest>=n or req_dest==my_addr: pulse err_dest the next cycle, emit no flit, stay in IDLE, and leave seq unchanged.
REQ-025 SHALL otherwise go from IDLE to HEAD on acceptance.
REQ-026 SHALL, in HEAD with credits>0, register the head flit and set flit_valid for exactly one cycle, then go to BODY (len>0) or IDLE (len==0, type single).
REQ-027 SHALL increment seq modulo 16 when a packet completes.
REQ-028 SHALL hold HEAD with flit_valid low while credits==0.
REQ-029 SHALL assert data_ready combinationally in BODY when credits>0 and data_valid are both high.
REQ-030 SHALL register a body flit on each such edge.
REQ-031 SHALL emit the len-th payload flit as type tail, then go to IDLE and increment seq.
REQ-032 SHALL hold state in BODY with flit_valid low if data_valid or credits is low.
REQ-033 SHALL keep data_ready and flit_valid low in all states other than those stated above.
REQ-034 SHALL give latency as follows: accept edge k; head flit visible after edge k+1 if credits>0; each body flit visible after its data_ready edge.
REQ-035 SHALL maintain a credit counter of width 4, starting at CREDITS, decremented per emitted flit and incremented per credit_ret.
REQ-036 SHALL leave the credit counter unchanged when emission and credit_ret occur on the same edge.
REQ-037 SHALL, on credit_ret with credits==CREDITS and no emission, saturate the counter and set credit_err.
REQ-038 SHALL increment flits_sent per flit_valid, wrapping from 0xFFFF to 0.
REQ-039 SHALL ignore req_valid outside IDLE.
REQ-040 SHALL sample req_dest and req_len only at acceptance.

Reset
REQ-041 SHALL, on rst low at a posedge, set state=IDLE, credits=CREDITS, seq=0, flits_sent=0, flit_valid=0, flit_out=0, err_dest=0, credit_err=0, and data_ready=0.
REQ-042 SHALL abandon any partially sent packet on reset mid-packet, with no tail emitted.
REQ-043 SHALL raise req_ready in the first cycle after rst returns high.

Verification
REQ-044 SHALL cover: my_addr=2, n=4, req dest=3 len=2, data always valid, credits free -> head 0x...0_0832 (len=2, seq=0) then body, then tail type 10; flits_sent=3; seq=1.
REQ-045 SHALL cover: len=0, dest=0 -> single flit with type 11, one flit_valid cycle, then IDLE next cycle.
REQ-046 SHALL cover: dest=5 with n=4, and separately dest=my_addr -> err_dest one pulse, no flit_valid, and seq unchanged.
REQ-047 SHALL cover: CREDITS=2, len=4, no credit_ret -> head and one body emitted, then stall; a single credit_ret resumes exactly one flit.
REQ-048 SHALL cover: credit_ret on the same edge as an emitted flit -> count unchanged; credit_ret at full -> credit_err=1 and held.
REQ-049 SHALL cover: rst low during BODY -> all outputs at reset values next cycle; a new request afterwards produces a head with seq=0.

Source files
------------

// File: rtl/ring_ni_tx.sv
// Ring network-interface transmit side: turns packet requests plus payload words
// into head/body/tail flits for the local router FIFO under credit flow control.
module ring_ni_tx #(
    parameter int unsigned CREDITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  my_addr,
    input  logic [3:0]  n,
    input  logic        req_valid,
    input  logic [3:0]  req_dest,
    input  logic [3:0]  req_len,
    output logic        req_ready,
    input  logic        data_valid,
    input  logic [53:0] data_in,
    output logic        data_ready,
    output logic [63:0] flit_out,
    output logic        flit_valid,
    input  logic        credit_ret,
    output logic        err_dest,
    output logic        credit_err,
    output logic [15:0] flits_sent
);

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    localparam logic [1:0] T_HEAD   = 2'b00;
    localparam logic [1:0] T_BODY   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t      state, state_nx;
    logic [3:0]  dest_q, len_q, cnt_q, seq_q, credits_q;
    logic [63:0] flit_nx;
    logic        have_credit, dest_bad;
    logic        emit, accept, reject, done;

    assign have_credit = (credits_q != 4'd0);
    assign dest_bad    = (req_dest >= n) || (req_dest == my_addr);
    assign req_ready   = (state == IDLE);

    always_comb begin
        state_nx   = state;
        flit_nx    = '0;
        emit       = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        done       = 1'b0;
        data_ready = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (dest_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = HEAD;
                    end
                end
            end
            HEAD: begin
                if (have_credit) begin
                    emit = 1'b1;
                    if (len_q == 4'd0) begin
                        flit_nx  = {46'b0, seq_q, len_q, T_SINGLE, dest_q, my_addr};
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        flit_nx  = {46'b0, seq_q, len_q, T_HEAD, dest_q, my_addr};
                        state_nx = BODY;
                    end
                end
            end
            BODY: begin
                if (have_credit && data_valid) begin
                    data_ready = 1'b1;
                    emit       = 1'b1;
                    // cnt_q counts payload flits already sent, so len-1 marks the last one
                    if (cnt_q == len_q - 4'd1) begin
                        flit_nx  = {data_in, T_TAIL, dest_q, my_addr};
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        flit_nx  = {data_in, T_BODY, dest_q, my_addr};
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            dest_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            seq_q      <= '0;
            credits_q  <= CRED_MAX;
            flits_sent <= '0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
            err_dest   <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            state      <= state_nx;
            flit_valid <= emit;
            err_dest   <= reject;
            if (emit) begin
                flit_out   <= flit_nx;
                flits_sent <= flits_sent + 16'd1;
            end
            if (accept) begin
                dest_q <= req_dest;
                len_q  <= req_len;
                cnt_q  <= '0;
            end else if (data_ready) begin
                cnt_q <= cnt_q + 4'd1;
            end
            if (done) begin
                seq_q <= seq_q + 4'd1;
            end
            // a return on the same edge as an emission cancels out
            if (emit && !credit_ret) begin
                credits_q <= credits_q - 4'd1;
            end else if (credit_ret && !emit) begin
                if (credits_q == CRED_MAX) begin
                    credit_err <= 1'b1;
                end else begin
                    credits_q <= credits_q + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ring_ni_tx.sv
// Directed plus randomized bench for ring_ni_tx, checked cycle by cycle against
// a packet-level reference model kept in this file.
module tb_ring_ni_tx;

    localparam int unsigned C = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  my_addr, n, req_dest, req_len;
    logic        req_valid, req_ready, data_valid, data_ready;
    logic [53:0] data_in;
    logic [63:0] flit_out;
    logic        flit_valid, credit_ret, err_dest, credit_err;
    logic [15:0] flits_sent;

    always #5 clk = ~clk;

    ring_ni_tx #(.CREDITS(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .my_addr    (my_addr),
        .n          (n),
        .req_valid  (req_valid),
        .req_dest   (req_dest),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_ready (data_ready),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .credit_ret (credit_ret),
        .err_dest   (err_dest),
        .credit_err (credit_err),
        .flits_sent (flits_sent)
    );

    int n_vec = 0;
    int n_err = 0;

    // Packet-level model: busy/head_due describe packet progress, rem counts payload left.
    bit          m_busy, m_head_due, m_cerr;
    int          m_rem, m_len, m_dest, m_seq, m_cred, m_sent;
    bit          e_emit, e_err, e_rst;
    logic [63:0] e_flit;
    int          obs_flits = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int dest, input int typ, input logic [53:0] pay);
        mk = {pay, 2'(typ), 4'(dest), my_addr};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_head_due = 0; m_cerr = 0;
        m_rem = 0; m_len = 0; m_dest = 0; m_seq = 0; m_cred = C; m_sent = 0;
    endtask

    task automatic cycle();
        bit bad, exp_dr;
        @(negedge clk);
        bad    = (req_dest >= n) || (req_dest == my_addr);
        exp_dr = m_busy && !m_head_due && data_valid && (m_cred > 0);
        check("req_ready", req_ready, !m_busy);
        check("data_ready", data_ready, exp_dr);
        e_emit = 0; e_err = 0; e_flit = '0; e_rst = !rst;
        if (!rst) begin
            model_reset();
        end else begin
            if (!m_busy) begin
                if (req_valid) begin
                    if (bad) e_err = 1;
                    else begin
                        m_busy = 1; m_head_due = 1; m_dest = req_dest; m_len = req_len;
                    end
                end
            end else if (m_head_due) begin
                if (m_cred > 0) begin
                    e_emit = 1; m_head_due = 0;
                    e_flit = mk(m_dest, (m_len == 0) ? 3 : 0, 54'(m_seq * 16 + m_len));
                    if (m_len == 0) begin
                        m_busy = 0; m_seq = (m_seq + 1) % 16;
                    end else m_rem = m_len;
                end
            end else if (exp_dr) begin
                e_emit = 1; m_rem--;
                e_flit = mk(m_dest, (m_rem == 0) ? 2 : 1, data_in);
                if (m_rem == 0) begin
                    m_busy = 0; m_seq = (m_seq + 1) % 16;
                end
            end
            if (e_emit && !credit_ret) m_cred--;
            else if (credit_ret && !e_emit) begin
                if (m_cred == C) m_cerr = 1;
                else m_cred++;
            end
            if (e_emit) m_sent = (m_sent + 1) % 65536;
        end
        @(posedge clk);
        #1;
        if (flit_valid) obs_flits++;
        check("flit_valid", flit_valid, e_emit);
        if (e_emit || e_rst) check("flit_out", flit_out, e_flit);
        check("err_dest", err_dest, e_err);
        check("credit_err", credit_err, m_cerr);
        check("flits_sent", flits_sent, 64'(m_sent));
    endtask

    task automatic quiet();
        req_valid = 0; credit_ret = 0; data_valid = 0;
        data_in = 54'({$urandom(), $urandom()});
    endtask

    initial begin
        model_reset();
        rst = 0; my_addr = 4'd2; n = 4'd4; req_dest = 0; req_len = 0;
        quiet();
        cycle(); cycle();
        rst = 1;
        cycle();

        // 3-flit packet, credits returned alongside each emission
        req_valid = 1; req_dest = 3; req_len = 2; data_valid = 1;
        cycle();
        req_valid = 0; credit_ret = 1;
        cycle();
        check("head_0832", flit_out, 64'h0000_0000_0000_0832);
        data_in = 54'({$urandom(), $urandom()}); cycle();
        data_in = 54'({$urandom(), $urandom()}); cycle();
        check("tail_type", 64'(flit_out[9:8]), 64'd2);
        check("sent_3", flits_sent, 64'd3);
        quiet(); cycle();

        // single flit, seq now 1
        req_valid = 1; req_dest = 0; req_len = 0;
        cycle();
        req_valid = 0; credit_ret = 1;
        cycle();
        check("single_4302", flit_out, 64'h0000_0000_0000_4302);
        credit_ret = 0;
        cycle();
        check("idle_after_single", req_ready, 1'b1);

        // rejected destinations leave seq untouched
        req_valid = 1; req_dest = 5; cycle();
        req_dest = 2; cycle();
        req_valid = 0; cycle();
        req_valid = 1; req_dest = 1; req_len = 0; cycle();
        req_valid = 0; credit_ret = 1; cycle();
        check("seq_kept_8312", flit_out, 64'h0000_0000_0000_8312);
        quiet(); cycle();

        // credit starvation: 2 credits, len 4
        obs_flits = 0;
        req_valid = 1; req_dest = 3; req_len = 4; data_valid = 1;
        cycle();
        req_valid = 0;
        for (int i = 0; i < 5; i++) cycle();
        check("stall_2flits", 64'(obs_flits), 64'd2);
        credit_ret = 1; cycle();
        credit_ret = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("resume_1flit", 64'(obs_flits), 64'd3);
        credit_ret = 1;
        for (int i = 0; i < 20 && m_busy; i++) begin
            data_in = 54'({$urandom(), $urandom()});
            cycle();
        end
        check("drained", 64'(m_busy), 64'd0);
        quiet(); credit_ret = 1; cycle();

        // overflow at full credit is sticky
        credit_ret = 1; cycle();
        credit_ret = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("credit_err_held", credit_err, 1'b1);

        // reset in the middle of a packet
        req_valid = 1; req_dest = 3; req_len = 5; data_valid = 1;
        cycle();
        req_valid = 0;
        cycle(); cycle();
        rst = 0; cycle();
        rst = 1; quiet();
        check("rst_flit_valid", flit_valid, 1'b0);
        check("rst_credit_err", credit_err, 1'b0);
        check("rst_flits_sent", flits_sent, 64'd0);
        cycle();
        req_valid = 1; req_dest = 3; req_len = 0; cycle();
        req_valid = 0; cycle();
        check("seq0_after_rst", flit_out, 64'h0000_0000_0000_0332);

        // randomized traffic with occasional resets and node reconfiguration
        for (int seg = 0; seg < 4; seg++) begin
            quiet(); rst = 0;
            my_addr = 4'($urandom_range(0, 15));
            n = 4'($urandom_range(1, 15));
            cycle();
            for (int i = 0; i < 250; i++) begin
                rst = ($urandom_range(0, 199) != 0);
                req_valid = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) req_dest = 4'($urandom_range(0, 15));
                else req_dest = 4'($urandom_range(0, int'(n) - 1));
                req_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 4));
                data_valid = ($urandom_range(0, 3) != 0);
                data_in = 54'({$urandom(), $urandom()});
                credit_ret = (m_cred < C) && ($urandom_range(0, 1) == 1);
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
